// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Purpose  : Shared definitions for the register-file slice: default register
//            width, the INIT/RUN state encoding and the address-width helper.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int XLEN_DEFAULT = 32;

    // INIT scrubs the array one register per cycle; RUN serves traffic.
    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Address width for a register count that is a power of two.
    function automatic int aw_f(input int nregs);
        return $clog2(nregs);
    endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : riscv_scoreboard
// Purpose  : Pending-write busy bits, one per register. Set on issue, clear
//            on writeback; a set and a clear to the same register in one
//            cycle leaves it set. busy_next is the post-update vector, which
//            is also what gets registered.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            set_en/set_addr - issue (already qualified: RUN, addr != 0)
//            clr_en/clr_addr - writeback (already qualified)
//            busy_next       - busy vector after this cycle's update
// Revision : 1.0 - initial release
// ============================================================================
module riscv_scoreboard
    import riscv_pkg::*;
#(
    parameter  int NREGS = 32,
    localparam int AW    = aw_f(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_en,
    input  logic [AW-1:0]    set_addr,
    input  logic             clr_en,
    input  logic [AW-1:0]    clr_addr,
    output logic [NREGS-1:0] busy_next
);

    logic [NREGS-1:0] busy_q;

    always_comb begin
        busy_next = busy_q;
        if (clr_en) begin
            busy_next[clr_addr] = 1'b0;
        end
        // Set applied last so it wins over a same-cycle clear.
        if (set_en) begin
            busy_next[set_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/riscv_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : riscv_regfile_sb
// Purpose  : Multi-read-port register file with a write-pending scoreboard.
//            After reset the array is scrubbed to zero one register per
//            cycle (INIT); then it serves registered reads with optional
//            same-cycle write forwarding (RUN).
// Ports    : clk, rst            - clock, synchronous active-high reset
//            ready               - high in RUN
//            rd_en/rd_addr       - per-port read request (port i at i*AW)
//            rd_data/rd_busy     - per-port registered data and busy flag
//            wr_en/wr_addr/wr_data - writeback
//            iss_en/iss_addr     - issue of an instruction writing iss_addr
// Revision : 1.0 - initial release
// ============================================================================
module riscv_regfile_sb
    import riscv_pkg::*;
#(
    parameter  int XLEN   = XLEN_DEFAULT,
    parameter  int NREGS  = 32,
    parameter  int NRD    = 2,
    parameter  int BYPASS = 1,
    localparam int AW     = aw_f(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    output logic                ready,
    input  logic [NRD-1:0]      rd_en,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr
);

    state_e           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic             run;
    logic             wr_ok;
    logic             iss_ok;
    logic [NREGS-1:0] busy_next;

    assign run    = (state_q == RUN);
    assign ready  = run;
    // x0 is hardwired: writes and issues to it never take effect.
    assign wr_ok  = run && wr_en  && (wr_addr  != '0);
    assign iss_ok = run && iss_en && (iss_addr != '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        regs_d  = regs_q;
        if (!run) begin
            regs_d[cnt_q] = '0;
            cnt_d         = cnt_q + AW'(1);
            if (cnt_q == AW'(NREGS - 1)) begin
                state_d = RUN;
            end
        end else if (wr_ok) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Array contents need no reset: the scrub that follows reset clears them,
    // and holding them during rst drops any write in the reset cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            regs_q <= regs_d;
        end
    end

    riscv_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .set_en    (iss_ok),
        .set_addr  (iss_addr),
        .clr_en    (wr_ok),
        .clr_addr  (wr_addr),
        .busy_next (busy_next)
    );

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data_q, data_d;
        logic            busy_q, busy_d;

        assign addr = rd_addr[i*AW +: AW];

        always_comb begin
            data_d = data_q;
            busy_d = busy_q;
            if (run && rd_en[i]) begin
                if (addr == '0) begin
                    data_d = '0;
                    busy_d = 1'b0;
                end else begin
                    if ((BYPASS != 0) && wr_ok && (wr_addr == addr)) begin
                        data_d = wr_data;
                    end else begin
                        data_d = regs_q[addr];
                    end
                    // Post-update busy keeps flag consistent with forwarded data.
                    busy_d = busy_next[addr];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                data_q <= '0;
                busy_q <= 1'b0;
            end else begin
                data_q <= data_d;
                busy_q <= busy_d;
            end
        end

        assign rd_data[i*XLEN +: XLEN] = data_q;
        assign rd_busy[i]              = busy_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_riscv_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_regfile_sb
// Purpose  : Directed self-checking bench. dut has three read ports with
//            forwarding; dut_nb shares port-0 stimulus without forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic        ready, ready_nb;
    logic [2:0]  rd_en;
    logic [14:0] rd_addr;
    logic [95:0] rd_data;
    logic [2:0]  rd_busy;
    logic [31:0] rd_data_nb;
    logic [0:0]  rd_busy_nb;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        iss_en;
    logic [4:0]  iss_addr;

    int n_chk  = 0;
    int n_pass = 0;
    int n;

    always #5 clk = ~clk;

    riscv_regfile_sb #(.XLEN(32), .NREGS(32), .NRD(3), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .ready(ready),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr)
    );

    riscv_regfile_sb #(.XLEN(32), .NREGS(32), .NRD(1), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .ready(ready_nb),
        .rd_en(rd_en[0:0]), .rd_addr(rd_addr[4:0]), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_en  = '0;
        wr_en  = 1'b0;
        iss_en = 1'b0;
    endtask

    task automatic set_rd(input int port, input logic [4:0] a);
        rd_addr[port*5 +: 5] = a;
    endtask

    function automatic logic [31:0] port_data(input int port);
        return rd_data[port*32 +: 32];
    endfunction

    initial begin
        idle();
        rd_addr  = '0;
        wr_addr  = '0;
        wr_data  = '0;
        iss_addr = '0;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_ready", ready, 0);
        check("rst_data", rd_data, 0);
        check("rst_busy", rd_busy, 0);

        // Scrub length
        n = 0;
        while (!ready && n < 100) begin
            tick();
            n++;
        end
        check("scrub_len", n, 32);
        check("scrub_ready_nb", ready_nb, 1);

        // All non-zero registers read zero after the scrub
        for (int r = 1; r < 32; r++) begin
            rd_en = 3'b001;
            set_rd(0, 5'(r));
            tick();
            check($sformatf("scrub_x%0d", r), port_data(0), 0);
        end

        // Forwarding vs. pre-write read on x5
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        rd_en = 3'b001; set_rd(0, 5'd5);
        tick();
        check("byp_x5", port_data(0), 32'hDEADBEEF);
        check("nobyp_x5_old", rd_data_nb, 0);
        wr_en = 1'b0;
        tick();
        check("nobyp_x5_new", rd_data_nb, 32'hDEADBEEF);

        // x0 writes discarded, reads zero
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
        rd_en = 3'b111; set_rd(0, 5'd0); set_rd(1, 5'd0); set_rd(2, 5'd0);
        tick();
        check("x0_byp_data", rd_data, 0);
        wr_en = 1'b0;
        tick();
        check("x0_data", rd_data, 0);
        check("x0_busy", rd_busy, 0);

        // Scoreboard on x7
        idle();
        iss_en = 1'b1; iss_addr = 5'd7;
        tick();
        iss_en = 1'b0;
        rd_en = 3'b001; set_rd(0, 5'd7);
        tick();
        check("x7_busy_iss", rd_busy[0], 1);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h77;
        iss_en = 1'b1; iss_addr = 5'd7;
        tick();
        check("x7_busy_set_wins", rd_busy[0], 1);
        check("x7_data_byp", port_data(0), 32'h77);
        iss_en = 1'b0; wr_data = 32'h78;
        tick();
        check("x7_busy_clr", rd_busy[0], 0);
        check("x7_data_byp2", port_data(0), 32'h78);
        check("x7_nb_old", rd_data_nb, 32'h77);
        check("x7_nb_busy", rd_busy_nb, 0);

        // Double issue stays busy, single writeback clears
        idle();
        iss_en = 1'b1; iss_addr = 5'd7;
        tick();
        rd_en = 3'b001;
        tick();
        check("x7_double_iss", rd_busy[0], 1);
        idle();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h79;
        tick();
        wr_en = 1'b0; rd_en = 3'b001;
        tick();
        check("x7_dbl_clr", rd_busy[0], 0);
        check("x7_dbl_data", port_data(0), 32'h79);

        // Three ports on x3, then port 1 holds when disabled
        idle();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5A5A5A5;
        tick();
        wr_en = 1'b0;
        rd_en = 3'b111; set_rd(0, 5'd3); set_rd(1, 5'd3); set_rd(2, 5'd3);
        tick();
        check("x3_p0", port_data(0), 32'hA5A5A5A5);
        check("x3_p1", port_data(1), 32'hA5A5A5A5);
        check("x3_p2", port_data(2), 32'hA5A5A5A5);
        rd_en = 3'b101; set_rd(0, 5'd5); set_rd(1, 5'd5); set_rd(2, 5'd5);
        tick();
        check("hold_p0", port_data(0), 32'hDEADBEEF);
        check("hold_p1", port_data(1), 32'hA5A5A5A5);
        check("hold_p2", port_data(2), 32'hDEADBEEF);

        // Reset in RUN restarts the scrub
        idle();
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h55;
        tick();
        wr_en = 1'b0;
        iss_en = 1'b1; iss_addr = 5'd10;
        tick();
        iss_en = 1'b0;
        rd_en = 3'b011; set_rd(0, 5'd9); set_rd(1, 5'd10);
        tick();
        check("x9_pre", port_data(0), 32'h55);
        check("x10_busy_pre", rd_busy[1], 1);
        idle();
        rst = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'hAB;
        tick();
        rst = 1'b0;
        check("rst2_ready", ready, 0);
        check("rst2_data", rd_data, 0);
        check("rst2_busy", rd_busy, 0);
        // Traffic during the scrub must be ignored
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hFF;
        iss_en = 1'b1; iss_addr = 5'd11;
        rd_en = 3'b111; set_rd(0, 5'd9); set_rd(1, 5'd9); set_rd(2, 5'd9);
        n = 0;
        while (!ready && n < 100) begin
            tick();
            n++;
        end
        idle();
        check("rst2_len", n, 32);
        check("rst2_rd_ignored", rd_data, 0);
        rd_en = 3'b111; set_rd(0, 5'd9); set_rd(1, 5'd10); set_rd(2, 5'd11);
        tick();
        check("rst2_x9", port_data(0), 0);
        check("rst2_x10", port_data(1), 0);
        check("rst2_x11", port_data(2), 0);
        check("rst2_busy_clr", rd_busy, 0);
        rd_en = 3'b001; set_rd(0, 5'd12);
        tick();
        check("rst2_x12_dropped", port_data(0), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
